pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 66 ++++++
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: step size, next-PC source select
// and the word-alignment helper.
package pc_pkg;

    localparam int PC_STEP = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BR,
        SEL_JMP,
        SEL_RET,
        SEL_EXC
    } pc_sel_t;

    // Works on a 64-bit container so one helper serves every legal WIDTH.
    function automatic logic [63:0] align_mask(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a circular LIFO that silently overwrites its oldest
// entry when pushed while full.
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
    assign top     = mem_q[ptr_dec];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_MAX);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop) begin
            if (!empty) begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (push) begin
            ptr_d = ptr_inc;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: entry storage is not reset; the occupancy count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (rst && push && !pop) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: fixed-priority next-PC selection with word alignment. The
// return-address stack is compiled in only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_take,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump_take,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full
);
    pc_sel_t          sel;
    logic [WIDTH-1:0] pc_q, pc_d, target;
    logic             misalign_q, misalign_d, ret_miss;

    assign pc_plus4 = pc_q + WIDTH'(PC_STEP);
    assign pc       = pc_q;
    assign misalign = misalign_q;

`ifdef PC_SEQUENCER_RAS_EN
    logic [WIDTH-1:0] ras_top;
    logic             do_push, do_pop;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    logic unused_call;

    assign unused_call = call;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
`endif

    always_comb begin
        sel = SEL_SEQ;
        if (exc)              sel = SEL_EXC;
        else if (ret)         sel = SEL_RET;
        else if (jump_take)   sel = SEL_JMP;
        else if (branch_take) sel = SEL_BR;
        else if (stall)       sel = SEL_HOLD;
    end

    always_comb begin
        target   = pc_plus4;
        ret_miss = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
        do_push  = 1'b0;
        do_pop   = 1'b0;
`endif
        unique case (sel)
            SEL_HOLD: target = pc_q;
            SEL_BR:   target = pc_q + branch_off;
            SEL_JMP: begin
                target = jump_target;
`ifdef PC_SEQUENCER_RAS_EN
                do_push = call;
`endif
            end
            SEL_RET: begin
`ifdef PC_SEQUENCER_RAS_EN
                // An empty-stack return falls through to pc+4 and is flagged.
                if (ras_empty) begin
                    ret_miss = 1'b1;
                end else begin
                    target = ras_top;
                    do_pop = 1'b1;
                end
`else
                target = jump_target;
`endif
            end
            SEL_EXC:  target = EXC_VECTOR;
            default:  ;
        endcase
    end

    assign pc_d       = WIDTH'(align_mask(64'(target)));
    assign misalign_d = ret_miss ||
                        ((sel inside {SEL_BR, SEL_JMP, SEL_RET, SEL_EXC}) && (target[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// call/return sequences and a randomized run against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, branch_take, jump_take, call, ret, exc;
    logic [31:0] branch_off, jump_target;
    logic [31:0] pc, pc_plus4;
    logic        misalign, ras_empty, ras_full;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_stack[$];

    localparam int DEPTH = 4;

    typedef struct {
        string       name;
        logic        rst, stall, br, jmp, exc;
        logic [31:0] off, tgt;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch_take (branch_take),
        .branch_off  (branch_off),
        .jump_take   (jump_take),
        .jump_target (jump_target),
        .call        (call),
        .ret         (ret),
        .exc         (exc),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Behavioural model: applies the priority rules to the architectural state.
    task automatic model_step();
        logic [31:0] tgt;
        bit          redir;
        bit          miss;
        redir = 1'b1;
        miss  = 1'b0;
        if (!rst) begin
            m_pc  = 32'h0;
            m_mis = 1'b0;
            m_stack.delete();
            return;
        end
        if (exc) begin
            tgt = 32'h80;
        end else if (ret) begin
`ifdef PC_SEQUENCER_RAS_EN
            if (m_stack.size() == 0) begin
                tgt  = m_pc + 32'd4;
                miss = 1'b1;
            end else begin
                tgt = m_stack.pop_back();
            end
`else
            tgt = jump_target;
`endif
        end else if (jump_take) begin
`ifdef PC_SEQUENCER_RAS_EN
            if (call) begin
                m_stack.push_back(m_pc + 32'd4);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
            end
`endif
            tgt = jump_target;
        end else if (branch_take) begin
            tgt = m_pc + branch_off;
        end else if (stall) begin
            tgt   = m_pc;
            redir = 1'b0;
        end else begin
            tgt   = m_pc + 32'd4;
            redir = 1'b0;
        end
        m_mis = miss || (redir && (tgt[1:0] != 2'b00));
        m_pc  = tgt & 32'hFFFF_FFFC;
    endtask

    task automatic tick();
        bit e_empty, e_full;
        model_step();
        @(posedge clk);
        #1;
`ifdef PC_SEQUENCER_RAS_EN
        e_empty = (m_stack.size() == 0);
        e_full  = (m_stack.size() == DEPTH);
`else
        e_empty = 1'b1;
        e_full  = 1'b0;
`endif
        check("model_pc", pc, m_pc);
        check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("model_misalign", 32'(misalign), 32'(m_mis));
        check("model_ras_empty", 32'(ras_empty), 32'(e_empty));
        check("model_ras_full", 32'(ras_full), 32'(e_full));
    endtask

    task automatic clr();
        rst         = 1'b1;
        stall       = 1'b0;
        branch_take = 1'b0;
        branch_off  = 32'h0;
        jump_take   = 1'b0;
        jump_target = 32'h0;
        call        = 1'b0;
        ret         = 1'b0;
        exc         = 1'b0;
    endtask

    function automatic vec_t mk(string name, logic r, logic st, logic br, logic [31:0] off,
                                logic jmp, logic [31:0] tgt, logic ex,
                                logic [31:0] epc, logic emis);
        vec_t v;
        v.name = name; v.rst = r; v.stall = st; v.br = br; v.off = off;
        v.jmp = jmp; v.tgt = tgt; v.exc = ex; v.exp_pc = epc; v.exp_mis = emis;
        return v;
    endfunction

    initial begin
        clr();
        rst = 1'b0;

        //                 name                  rst st br off           jmp tgt           exc exp_pc        mis
        vecs.push_back(mk("reset",               0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk("seq_4",               1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h4,       0));
        vecs.push_back(mk("seq_8",               1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h8,       0));
        vecs.push_back(mk("seq_12",              1, 0, 0, 32'h0,       0, 32'h0,       0, 32'hC,       0));
        vecs.push_back(mk("seq_16",              1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h10,      0));
        vecs.push_back(mk("stall_1",             1, 1, 0, 32'h0,       0, 32'h0,       0, 32'h10,      0));
        vecs.push_back(mk("stall_2",             1, 1, 0, 32'h0,       0, 32'h0,       0, 32'h10,      0));
        vecs.push_back(mk("branch_back",         1, 0, 1, 32'hFFFFFFF8, 0, 32'h0,      0, 32'h8,       0));
        vecs.push_back(mk("exc_beats_all",       1, 1, 0, 32'h0,       1, 32'h300,     1, 32'h80,      0));
        vecs.push_back(mk("jump_misaligned",     1, 0, 0, 32'h0,       1, 32'h103,     0, 32'h100,     1));
        vecs.push_back(mk("seq_after_mis",       1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h104,     0));
        vecs.push_back(mk("branch_misaligned",   1, 0, 1, 32'h2,       0, 32'h0,       0, 32'h104,     1));
        vecs.push_back(mk("branch_beats_stall",  1, 1, 1, 32'h10,      0, 32'h0,       0, 32'h114,     0));
        vecs.push_back(mk("jump_top",            1, 0, 0, 32'h0,       1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 0));
        vecs.push_back(mk("seq_wrap",            1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk("branch_wrap_down",    1, 0, 1, 32'hFFFFFFFC, 0, 32'h0,      0, 32'hFFFFFFFC, 0));
        vecs.push_back(mk("branch_wrap_up",      1, 0, 1, 32'h8,       0, 32'h0,       0, 32'h4,       0));
        vecs.push_back(mk("reset_beats_exc",     0, 0, 0, 32'h0,       1, 32'h300,     1, 32'h0,       0));
        vecs.push_back(mk("first_step",          1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h4,       0));
        vecs.push_back(mk("jump_mis_2",          1, 0, 0, 32'h0,       1, 32'h207,     0, 32'h204,     1));
        vecs.push_back(mk("reset_mid_redirect",  0, 0, 1, 32'h3,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk("stall_after_reset",   1, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0,       0));
        vecs.push_back(mk("step_after_stall",    1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h4,       0));

        foreach (vecs[i]) begin
            clr();
            rst         = vecs[i].rst;
            stall       = vecs[i].stall;
            branch_take = vecs[i].br;
            branch_off  = vecs[i].off;
            jump_take   = vecs[i].jmp;
            jump_target = vecs[i].tgt;
            exc         = vecs[i].exc;
            tick();
            check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
            check({vecs[i].name, "_mis"}, 32'(misalign), 32'(vecs[i].exp_mis));
        end

        clr(); rst = 1'b0; tick();
        clr(); jump_take = 1'b1; jump_target = 32'h20; tick();
        check("ras_setup_pc", pc, 32'h20);

`ifdef PC_SEQUENCER_RAS_EN
        clr(); call = 1'b1; jump_take = 1'b1; jump_target = 32'h100; tick();
        check("call_pc", pc, 32'h100);
        check("call_ras_empty", 32'(ras_empty), 32'h0);
        clr(); tick();
        check("call_body_pc", pc, 32'h104);
        clr(); ret = 1'b1; tick();
        check("ret_pc", pc, 32'h24);
        check("ret_ras_empty", 32'(ras_empty), 32'h1);
        check("ret_misalign", 32'(misalign), 32'h0);

        clr(); call = 1'b1; jump_take = 1'b1; jump_target = 32'h200; tick();
        clr(); exc = 1'b1; call = 1'b1; jump_take = 1'b1; jump_target = 32'h400; stall = 1'b1; tick();
        check("exc_stack_pc", pc, 32'h80);
        check("exc_stack_not_empty", 32'(ras_empty), 32'h0);
        clr(); ret = 1'b1; tick();
        check("exc_stack_ret_pc", pc, 32'h28);
        check("exc_stack_empty_after", 32'(ras_empty), 32'h1);

        for (int i = 1; i <= 5; i++) begin
            clr(); call = 1'b1; jump_take = 1'b1; jump_target = 32'(i * 32'h1000); tick();
            check("nest_call_pc", pc, 32'(i * 32'h1000));
            if (i >= 4) check("nest_ras_full", 32'(ras_full), 32'h1);
        end
        for (int i = 4; i >= 1; i--) begin
            clr(); ret = 1'b1; tick();
            check("nest_ret_pc", pc, 32'(i * 32'h1000 + 4));
            check("nest_ret_mis", 32'(misalign), 32'h0);
        end
        clr(); ret = 1'b1; tick();
        check("empty_ret_pc", pc, 32'h1008);
        check("empty_ret_mis", 32'(misalign), 32'h1);
        check("empty_ret_ras_empty", 32'(ras_empty), 32'h1);

        clr(); call = 1'b1; jump_take = 1'b1; jump_target = 32'h500; tick();
        clr(); ret = 1'b1; call = 1'b1; jump_take = 1'b1; jump_target = 32'h600; tick();
        check("ret_beats_call_pc", pc, 32'h100C);
        check("ret_beats_call_empty", 32'(ras_empty), 32'h1);
`else
        clr(); call = 1'b1; jump_take = 1'b1; jump_target = 32'h100; tick();
        check("noras_call_pc", pc, 32'h100);
        check("noras_ras_empty", 32'(ras_empty), 32'h1);
        check("noras_ras_full", 32'(ras_full), 32'h0);
        clr(); ret = 1'b1; jump_target = 32'h300; tick();
        check("noras_ret_pc", pc, 32'h300);
        check("noras_ret_mis", 32'(misalign), 32'h0);
        clr(); ret = 1'b1; jump_target = 32'h301; tick();
        check("noras_ret_mis_pc", pc, 32'h300);
        check("noras_ret_mis_flag", 32'(misalign), 32'h1);
`endif

        for (int n = 0; n < 400; n++) begin
            clr();
            rst         = ($urandom_range(0, 49) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            branch_take = ($urandom_range(0, 4) == 0);
            branch_off  = $urandom_range(0, 1) ? 32'h0 - 32'($urandom_range(0, 64))
                                               : 32'($urandom_range(0, 64));
            jump_take   = ($urandom_range(0, 3) == 0);
            jump_target = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
            call        = ($urandom_range(0, 2) == 0);
            ret         = ($urandom_range(0, 5) == 0);
            exc         = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
